// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serialiser.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_enc_state_t;

    // Line states as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LIMIT_DEF  = 6;
    localparam int EOP_SE0_BITS_DEF = 2;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line driver: on each strobe it toggles on a 0, holds on a 1,
// or forces SE0 / J during the end-of-packet sequence.
module usb_nrzi_enc
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic strobe_i,
    input  logic data_i,
    input  logic force_se0_i,
    input  logic force_j_i,
    output logic dplus_out,
    output logic dminus_out
);

    logic [1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (strobe_i) begin
            if (force_se0_i) begin
                line_d = LINE_SE0;
            end else if (force_j_i) begin
                line_d = LINE_J;
            end else if (!data_i) begin
                line_d = nrzi_toggle(line_q);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q <= LINE_J;
        end else begin
            line_q <= line_d;
        end
    end

    assign {dplus_out, dminus_out} = line_q;

endmodule

// File: rtl/usb_tx_encoder.sv
// USB TX serial back end: one-deep holding register, LSB-first shifter,
// bit stuffing and EOP sequencing, driving the NRZI line encoder.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF,
    parameter int EOP_SE0_BITS = EOP_SE0_BITS_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       shift_strobe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       send_eop,
    output logic       bit_stuff_en,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       busy,
    output logic       eop_done,
    output logic       underrun
);

    localparam logic [2:0] ONES_LIMIT = 3'(STUFF_LIMIT);
    localparam logic [3:0] SE0_LAST   = 4'(EOP_SE0_BITS - 1);

    tx_enc_state_t state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    shift_q, shift_d;
    logic          hold_full_q, hold_full_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic [2:0]    ones_inc;
    logic          stuff_q, stuff_d;
    logic          eop_pend_q, eop_pend_d;
    logic          last_q, last_d;
    logic [3:0]    se0_cnt_q, se0_cnt_d;
    logic          busy_q;
    logic          underrun_q, underrun_d;
    logic          eop_done_q, eop_done_d;
    logic          accept;
    logic          eop_req;

    assign accept   = tx_valid && !hold_full_q;
    assign eop_req  = eop_pend_q || send_eop;
    assign ones_inc = ones_cnt_q + 3'd1;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        stuff_d     = stuff_q;
        eop_pend_d  = eop_pend_q;
        last_d      = last_q;
        se0_cnt_d   = se0_cnt_q;
        underrun_d  = 1'b0;
        eop_done_d  = 1'b0;

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (send_eop && (state_q == IDLE || state_q == SHIFT)) begin
            eop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = accept;
                    bit_cnt_d   = 3'd0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_strobe) begin
                    if (stuff_q) begin
                        stuff_d    = 1'b0;
                        ones_cnt_d = 3'd0;
                        // The byte already ran out; the stuffed zero was the last thing owed.
                        if (last_q) begin
                            last_d    = 1'b0;
                            se0_cnt_d = 4'd0;
                            state_d   = EOP_SE0;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (shift_q[0]) begin
                            ones_cnt_d = ones_inc;
                            if (ones_inc == ONES_LIMIT) begin
                                stuff_d = 1'b1;
                            end
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                        if (bit_cnt_q == 3'd7) begin
                            if (hold_full_q) begin
                                shift_d     = hold_q;
                                hold_full_d = accept;
                                bit_cnt_d   = 3'd0;
                            end else begin
                                if (!eop_req) begin
                                    underrun_d = 1'b1;
                                    eop_pend_d = 1'b1;
                                end
                                if (stuff_d) begin
                                    last_d = 1'b1;
                                end else begin
                                    se0_cnt_d = 4'd0;
                                    state_d   = EOP_SE0;
                                end
                            end
                        end
                    end
                end
            end
            EOP_SE0: begin
                if (shift_strobe) begin
                    if (se0_cnt_q == SE0_LAST) begin
                        state_d = EOP_J;
                    end else begin
                        se0_cnt_d = se0_cnt_q + 4'd1;
                    end
                end
            end
            EOP_J: begin
                if (shift_strobe) begin
                    eop_done_d = 1'b1;
                    eop_pend_d = 1'b0;
                    ones_cnt_d = 3'd0;
                    stuff_d    = 1'b0;
                    last_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            ones_cnt_q  <= 3'd0;
            stuff_q     <= 1'b0;
            eop_pend_q  <= 1'b0;
            last_q      <= 1'b0;
            se0_cnt_q   <= 4'd0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            eop_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            stuff_q     <= stuff_d;
            eop_pend_q  <= eop_pend_d;
            last_q      <= last_d;
            se0_cnt_q   <= se0_cnt_d;
            busy_q      <= (state_d != IDLE);
            underrun_q  <= underrun_d;
            eop_done_q  <= eop_done_d;
        end
    end

    usb_nrzi_enc u_nrzi (
        .clk         (clk),
        .n_rst       (n_rst),
        .strobe_i    (shift_strobe && (state_q != IDLE)),
        .data_i      (stuff_q ? 1'b0 : shift_q[0]),
        .force_se0_i (state_q == EOP_SE0),
        .force_j_i   (state_q == EOP_J),
        .dplus_out   (dplus_out),
        .dminus_out  (dminus_out)
    );

    assign tx_ready     = ~hold_full_q;
    assign bit_stuff_en = stuff_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;
    assign eop_done     = eop_done_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: directed packets from the test plan
// plus random packets, compared against a bit-stream model of stuffing and NRZI.
`timescale 1ns/1ps
module tb_usb_tx_encoder;

    typedef logic [7:0] byte_q_t[$];

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       shift_strobe = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       send_eop = 1'b0;
    logic       tx_ready, bit_stuff_en, dplus_out, dminus_out, busy, eop_done, underrun;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_line[$];
    logic       exp_stuff[$];

    always #5 clk = ~clk;

    usb_tx_encoder dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_strobe (shift_strobe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .send_eop     (send_eop),
        .bit_stuff_en (bit_stuff_en),
        .dplus_out    (dplus_out),
        .dminus_out   (dminus_out),
        .busy         (busy),
        .eop_done     (eop_done),
        .underrun     (underrun)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level after each strobe of a packet: data bits LSB first,
    // a zero inserted after every six consecutive ones, NRZI, then SE0 SE0 J.
    task automatic build_model(input byte_q_t bytes);
        logic [1:0] line;
        int         ones;
        logic       b;
        exp_line.delete();
        exp_stuff.delete();
        line = J;
        ones = 0;
        foreach (bytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                b = bytes[i][k];
                if (!b) line = (line == J) ? K : J;
                exp_line.push_back(line);
                exp_stuff.push_back(1'b0);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    line = (line == J) ? K : J;
                    exp_line.push_back(line);
                    exp_stuff.push_back(1'b1);
                    ones = 0;
                end
            end
        end
        exp_line.push_back(SE0);
        exp_stuff.push_back(1'b0);
        exp_line.push_back(SE0);
        exp_stuff.push_back(1'b0);
        exp_line.push_back(J);
        exp_stuff.push_back(1'b0);
    endtask

    // Feeds a packet through the handshake, strobes every 8 clocks and
    // compares every strobe plus the end-of-packet state.
    task automatic run_packet(input string name, input byte_q_t bytes, input bit with_eop);
        byte_q_t feed;
        int      n_str, str_idx, under_cnt, done_cnt, total;
        bit      eop_sent, strobing, accepted;
        logic    pre_stuff;
        build_model(bytes);
        feed      = bytes;
        eop_sent  = !with_eop;
        str_idx   = 0;
        under_cnt = 0;
        done_cnt  = 0;
        n_str     = exp_line.size();
        total     = 4 + 8 * n_str + 8;
        for (int cyc = 0; cyc < total; cyc++) begin
            strobing = (cyc >= 4) && (((cyc - 4) % 8) == 0) && (str_idx < n_str);
            tx_valid = (feed.size() != 0);
            if (feed.size() != 0) tx_data = feed[0];
            else                  tx_data = 8'd0;
            send_eop = 1'b0;
            if (feed.size() == 0 && !eop_sent) begin
                send_eop = 1'b1;
                eop_sent = 1'b1;
            end
            accepted     = tx_valid && (tx_ready === 1'b1);
            shift_strobe = strobing;
            pre_stuff    = bit_stuff_en;
            tick();
            if (accepted) void'(feed.pop_front());
            if (underrun === 1'b1) under_cnt++;
            if (eop_done === 1'b1) done_cnt++;
            if (strobing) begin
                checks++;
                if ({dplus_out, dminus_out} !== exp_line[str_idx]) begin
                    errors++;
                    $display("FAIL %s line strobe %0d: got %b expected %b",
                             name, str_idx + 1, {dplus_out, dminus_out}, exp_line[str_idx]);
                end
                checks++;
                if (pre_stuff !== exp_stuff[str_idx]) begin
                    errors++;
                    $display("FAIL %s bit_stuff_en strobe %0d: got %b expected %b",
                             name, str_idx + 1, pre_stuff, exp_stuff[str_idx]);
                end
                if (str_idx == 0) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy in packet: got %b expected 1", name, busy);
                    end
                end
                str_idx++;
            end
        end
        shift_strobe = 1'b0;
        tx_valid     = 1'b0;
        send_eop     = 1'b0;
        checks++;
        if (feed.size() != 0) begin
            errors++;
            $display("FAIL %s bytes accepted: %0d left over, expected 0", name, feed.size());
        end
        checks++;
        if (under_cnt != (with_eop ? 0 : 1)) begin
            errors++;
            $display("FAIL %s underrun pulses: got %0d expected %0d", name, under_cnt, with_eop ? 0 : 1);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s eop_done pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (busy !== 1'b0 || tx_ready !== 1'b1 || {dplus_out, dminus_out} !== J) begin
            errors++;
            $display("FAIL %s end state: busy=%b tx_ready=%b line=%b expected 0 1 10",
                     name, busy, tx_ready, {dplus_out, dminus_out});
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dplus_out, dminus_out, tx_ready, bit_stuff_en, busy, eop_done, underrun} !== 7'b1010000) begin
            errors++;
            $display("FAIL reset values: got %b expected 1010000",
                     {dplus_out, dminus_out, tx_ready, bit_stuff_en, busy, eop_done, underrun});
        end
        n_rst = 1'b1;
        tick();
        checks++;
        if ({dplus_out, dminus_out, tx_ready, bit_stuff_en, busy, eop_done, underrun} !== 7'b1010000) begin
            errors++;
            $display("FAIL after reset release: got %b expected 1010000",
                     {dplus_out, dminus_out, tx_ready, bit_stuff_en, busy, eop_done, underrun});
        end
    endtask

    task automatic test_idle_strobes();
        for (int s = 0; s < 4; s++) begin
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            checks++;
            if ({dplus_out, dminus_out, tx_ready, busy, eop_done} !== 5'b10100) begin
                errors++;
                $display("FAIL idle strobe %0d: got %b expected 10100", s,
                         {dplus_out, dminus_out, tx_ready, busy, eop_done});
            end
            repeat (7) tick();
        end
    endtask

    task automatic test_sync_eop();
        byte_q_t p;
        p = '{8'h80};
        run_packet("sync_eop", p, 1'b1);
    endtask

    task automatic test_stuff_ff00();
        byte_q_t p;
        p = '{8'hFF, 8'h00};
        run_packet("stuff_ff00", p, 1'b1);
    endtask

    task automatic test_stuff_across_bytes();
        byte_q_t p;
        p = '{8'h3F, 8'h01};
        run_packet("stuff_3f01", p, 1'b1);
        p = '{8'hE0, 8'h07};
        run_packet("stuff_e007", p, 1'b1);
    endtask

    task automatic test_underrun();
        byte_q_t p;
        p = '{8'hFC};
        run_packet("underrun_fc", p, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        byte_q_t p;
        tx_valid = 1'b1;
        tx_data  = 8'hFE;
        tick();
        tx_data = 8'h55;
        tick();
        tick();
        tx_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            repeat (7) tick();
        end
        checks++;
        if ({dplus_out, dminus_out, tx_ready, busy} !== 4'b0101) begin
            errors++;
            $display("FAIL pre-reset state: got %b expected 0101", {dplus_out, dminus_out, tx_ready, busy});
        end
        #3;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({dplus_out, dminus_out, tx_ready, busy, bit_stuff_en} !== 5'b10100) begin
            errors++;
            $display("FAIL async reset mid-byte: got %b expected 10100",
                     {dplus_out, dminus_out, tx_ready, busy, bit_stuff_en});
        end
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        p = '{8'h3F};
        run_packet("after_reset_3f", p, 1'b1);
    endtask

    task automatic test_random_packets();
        byte_q_t p;
        int      len;
        logic [7:0] b;
        for (int n = 0; n < 8; n++) begin
            p.delete();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) b = b | 8'($urandom);
                p.push_back(b);
            end
            run_packet($sformatf("random_%0d", n), p, ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_idle_strobes();
        test_sync_eop();
        test_stuff_ff00();
        test_stuff_across_bytes();
        test_underrun();
        test_reset_mid_packet();
        test_random_packets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Serial back end of the USB TX path: accepts bytes from the TX packet controller through a one-deep holding register and shifts them out LSB-first on each bit strobe from `usb_timer`. It performs bit stuffing, NRZI encoding and EOP generation, and drives the full-speed D+/D− line pair. It also returns `bit_stuff_en` to `usb_timer`, so the timer's bit counter does not advance on stuffed bits.

## Interface
Parameters:
- `STUFF_LIMIT`, default 6: consecutive transmitted ones that force a stuffed zero.
- `EOP_SE0_BITS`, default 2: number of SE0 bit times in an EOP.

Ports:
- `clk`  in  1  system clock; the only clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `shift_strobe`  in  1  one-cycle bit-time strobe, driven by `usb_timer.clk12`.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  holding register empty; a byte transfers when `tx_valid && tx_ready`.
- `send_eop`  in  1  one-cycle pulse: end the packet after the last queued byte.
- `bit_stuff_en`  out  1  high while a stuffed zero is pending or being emitted.
- `dplus_out`  out  1  D+ line.
- `dminus_out`  out  1  D− line.
- `busy`  out  1  state is not IDLE.
- `eop_done`  out  1  one-cycle pulse when the EOP J bit completes.
- `underrun`  out  1  one-cycle pulse when the shift register empties with no byte and no EOP request.

## Operation
- State machine with states IDLE, SHIFT, EOP_SE0 and EOP_J.

IDLE
- Line is driven to J (D+ = 1, D− = 0). The NRZI register holds J and the ones count is 0.
- When the holding register is full, its byte moves to the shift register, bit count is set to 0, and the state goes to SHIFT.

SHIFT, on each `shift_strobe`
- If a stuff is pending: emit 0, do not shift, clear the pending flag and set ones count to 0.
- Otherwise: emit `shift_reg[0]`, shift right and increment the bit count.
  - A emitted 1 increments the ones count. When it reaches `STUFF_LIMIT`, the stuff flag is set.
  - A emitted 0 clears the ones count.
- The ones count is kept across byte boundaries within a packet.

After the strobe that emits the 8th data bit of a byte
- Holding register full: its byte loads into the shift register.
- Otherwise, if EOP is pending: go to EOP_SE0 once the stuff flag is clear. A pending stuffed zero is still sent first.
- Otherwise: pulse `underrun`, set EOP pending, and take the EOP path.

NRZI encoding
- An emitted 0 toggles the line between J and K.
- An emitted 1 holds the line.

EOP
- EOP_SE0 drives D+ = D− = 0 for `EOP_SE0_BITS` strobes.
- EOP_J then drives J for 1 strobe, pulses `eop_done` and returns to IDLE.
- Entering IDLE clears EOP pending, the ones count and the NRZI register (NRZI → J).

Other rules
- `send_eop` sets a sticky EOP-pending flag. It is ignored in EOP_SE0 and EOP_J.
- Holding register: `tx_ready = !hold_full`. A simultaneous accept and transfer to the shift register leaves the holding register full.

## Timing
- Reset values: `dplus_out` = 1, `dminus_out` = 0, `tx_ready` = 1, `bit_stuff_en` = 0, `busy` = 0, `eop_done` = 0, `underrun` = 0. State is IDLE and all counters are 0.
- All outputs are registered. The line outputs change on the clock edge that samples `shift_strobe` high.
- Holding register to shift register in IDLE takes 1 cycle. The first bit goes out on the next strobe.
- `bit_stuff_en` rises on the edge after the strobe that emits the 6th one. It stays high through the stuff strobe and falls on that strobe's edge, so it is high when the timer samples its halt.
- Strobes are ignored in IDLE.
- Reset asserted mid-packet returns the block to IDLE with J on the line immediately (asynchronous).

## Structure
- Package `usb_tx_pkg` holds:
  - the state enum `tx_enc_state_t`;
  - line constants `LINE_J`, `LINE_K`, `LINE_SE0` as 2-bit {D+, D−} values;
  - `STUFF_LIMIT_DEF` and `EOP_SE0_BITS_DEF`.
- Sub-module `usb_nrzi_enc` takes strobe, data bit, force_se0 and force_j, and registers `dplus_out`/`dminus_out`.
- The main module contains the FSM, the holding and shift registers, the bit count (3 bits) and the ones count (3 bits).

## Test plan
- Reset, then idle with strobes every 8 clocks → `dplus_out` = 1, `dminus_out` = 0, `tx_ready` = 1, `busy` = 0, no `eop_done`.
- Send 0x80 (SYNC) then `send_eop` → line K J K J K J K K, then SE0, SE0, J; `eop_done` pulses once; return to IDLE.
- Send 0xFF, 0x00 → six holds, stuffed toggle with `bit_stuff_en` high on the 7th strobe, two holds, then eight toggles. Total 17 strobes.
- Send 0x3F, 0x01 → the 6-ones run completes at bit 5; the stuffed zero is inserted before bit 6; the ones count persists across the byte boundary.
- Send 0xFC then no further byte and no `send_eop` → `underrun` pulses once after the 8th bit, followed by EOP and `eop_done`.
- Assert `n_rst` low mid-byte → outputs immediately return to J, `tx_ready` = 1, `busy` = 0; the next packet starts cleanly with ones count 0.
